// File: rtl/hazard_scheduler.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX write, flush and bubble control
// for load-use hazards, taken branches and multi-cycle data-memory waits.
module hazard_scheduler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             Branch_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             pipe_stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               freeze_s;
  logic               load_use_s;

  // Hazard detection and next-state / counter computation
  always_comb begin
    load_use_s  = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                  ((IDEX_RDaddr_i == IFID_RS1addr_i) || (IDEX_RDaddr_i == IFID_RS2addr_i));
    freeze_s    = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (dmem_req_i && !dmem_ack_i) begin
          freeze_s   = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          freeze_s   = 1'b0;
        end
      end
      // A dropped dmem_req_i here is a protocol violation; keep waiting for ack.
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          freeze_s   = 1'b1;
          state_d    = ERROR;
        end else begin
          freeze_s   = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ERROR: begin
        freeze_s = 1'b1;
      end
      default: begin
        freeze_s   = 1'b1;
        state_d    = ERROR;
      end
    endcase

    if ((freeze_s || load_use_s) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Zero-latency pipeline controls, prioritised freeze > load-use > branch
  always_comb begin
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IFIDFlush_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    pipe_stall_o = 1'b0;
    if (rst_i) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXBubble_o = 1'b1;
    end else if (freeze_s) begin
      pipe_stall_o = 1'b1;
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
    end else if (load_use_s) begin
      // Branch is dropped here; it re-resolves once the load has moved on.
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXBubble_o = 1'b1;
    end else if (Branch_i) begin
      IFIDFlush_o  = 1'b1;
    end else begin
      IFIDFlush_o  = 1'b0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err_o       = (state_q == ERROR);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mr = 1'b0;
  logic [4:0] rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic       br = 1'b0, req = 1'b0, ack = 1'b0;
  logic       pcw, ifw, flush, bubble, stall, err;
  logic [3:0] cnt;

  // Expected control vector order: {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, pipe_stall, err}
  localparam logic [5:0] RUNV = 6'b110000;
  localparam logic [5:0] LU   = 6'b000100;
  localparam logic [5:0] BR   = 6'b111000;
  localparam logic [5:0] FRZ  = 6'b000010;
  localparam logic [5:0] FRZE = 6'b000011;
  localparam logic [5:0] RSTV = 6'b000100;

  typedef struct packed {
    logic [5:0] ctl;
    logic [3:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  hazard_scheduler #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IDEX_MemRead_i (mr),
    .IDEX_RDaddr_i  (rd),
    .IFID_RS1addr_i (rs1),
    .IFID_RS2addr_i (rs2),
    .Branch_i       (br),
    .dmem_req_i     (req),
    .dmem_ack_i     (ack),
    .PCWrite_o      (pcw),
    .IFIDWrite_o    (ifw),
    .IFIDFlush_o    (flush),
    .IDEXBubble_o   (bubble),
    .pipe_stall_o   (stall),
    .err_o          (err),
    .stall_cnt_o    (cnt)
  );

  always #5 clk = ~clk;

  // Monitor: compare one expected entry per cycle, mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic [5:0] act;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {pcw, ifw, flush, bubble, stall, err};
      vectors++;
      if (act !== e.ctl || cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 nm, act, cnt, e.ctl, e.cnt);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic m,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic b, input logic rq, input logic ak,
                      input logic [5:0] ectl, input logic [3:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mr = m; rd = d; rs1 = s1; rs2 = s2; br = b; req = rq; ack = ak;
    e.ctl = ectl;
    e.cnt = ecnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    //    name           rst mr  rd     rs1    rs2    br   req  ack   ctl   cnt
    step("reset",        1,  0,  5'd0,  5'd0,  5'd0,  0,   0,   0,    RSTV, 4'd0);
    step("idle",         0,  0,  5'd0,  5'd0,  5'd0,  0,   0,   0,    RUNV, 4'd0);
    step("load_use",     0,  1,  5'd5,  5'd5,  5'd0,  0,   0,   0,    LU,   4'd0);
    step("x0_no_stall",  0,  1,  5'd0,  5'd0,  5'd0,  0,   0,   0,    RUNV, 4'd1);
    step("lu_branch",    0,  1,  5'd7,  5'd0,  5'd7,  1,   0,   0,    LU,   4'd1);
    step("branch",       0,  0,  5'd7,  5'd0,  5'd7,  1,   0,   0,    BR,   4'd2);
    step("zero_wait",    0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   1,    RUNV, 4'd2);
    step("wait1",        0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    FRZ,  4'd2);
    step("wait2",        0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    FRZ,  4'd3);
    step("wait3",        0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    FRZ,  4'd4);
    step("ack_advance",  0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   1,    RUNV, 4'd5);
    step("back_in_run",  0,  0,  5'd0,  5'd0,  5'd0,  0,   0,   0,    RUNV, 4'd5);
    // Timeout with TIMEOUT_CYCLES=4; the first cycle also shows freeze beating load-use
    step("to_frz_lu",    0,  1,  5'd5,  5'd5,  5'd0,  0,   1,   0,    FRZ,  4'd5);
    step("to_w1",        0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    FRZ,  4'd6);
    step("to_w2",        0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    FRZ,  4'd7);
    step("to_w3",        0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    FRZ,  4'd8);
    step("to_error",     0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    FRZE, 4'd9);
    step("late_ack",     0,  0,  5'd0,  5'd0,  5'd0,  0,   0,   1,    FRZE, 4'd10);
    for (int i = 0; i < 12; i++) begin
      step("saturate",   0,  0,  5'd0,  5'd0,  5'd0,  0,   0,   0,    FRZE,
           (i < 4) ? 4'(11 + i) : 4'd15);
    end
    step("rst_pulse",    1,  0,  5'd0,  5'd0,  5'd0,  0,   0,   0,    RSTV, 4'd0);
    step("post_rst",     0,  0,  5'd0,  5'd0,  5'd0,  0,   0,   0,    RUNV, 4'd0);
    step("mw_a",         0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    FRZ,  4'd0);
    step("mw_b",         0,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    FRZ,  4'd1);
    // Reset raised between edges: outputs must change before the next clock edge
    step("async_rst",    1,  0,  5'd0,  5'd0,  5'd0,  0,   1,   0,    RSTV, 4'd0);
    step("post_rst2",    0,  0,  5'd0,  5'd0,  5'd0,  0,   0,   0,    RUNV, 4'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It decides each cycle whether PC, IF/ID and ID/EX advance, hold, bubble or flush. It covers load-use hazards, taken-branch flushes and multi-cycle data-memory waits, with a timeout watchdog and a saturating stall performance counter. It sits beside the hazard/forwarding logic and drives the write-enable and flush controls of PC, IF/ID and the ID/EX register.

Parameters:
TIMEOUT_CYCLES, 64, max consecutive MEM_WAIT cycles before error (>=2)
CNT_W, 16, width of stall performance counter

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous reset, active-high
IDEX_MemRead_i  input  1  instruction in EX is a load
IDEX_RDaddr_i  input  5  destination register of instruction in EX
IFID_RS1addr_i  input  5  rs1 of instruction in ID
IFID_RS2addr_i  input  5  rs2 of instruction in ID
Branch_i  input  1  taken branch resolved in ID this cycle
dmem_req_i  input  1  MEM stage holds a load/store this cycle
dmem_ack_i  input  1  data memory completes the MEM-stage access this cycle
PCWrite_o  output  1  PC may update
IFIDWrite_o  output  1  IF/ID may load
IFIDFlush_o  output  1  IF/ID loads a NOP
IDEXBubble_o  output  1  ID/EX loads all-zero control signals
pipe_stall_o  output  1  freeze every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
err_o  output  1  memory timeout, sticky
stall_cnt_o  output  CNT_W  stalled-cycle count, saturating

Behaviour:
- Reset (rst_i=1, asynchronous): state=RUN, wait_cnt=0, stall_cnt_o=0, err_o=0.
- Outputs while rst_i=1: PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0, IDEXBubble_o=1, pipe_stall_o=0.
- Reset mid-MEM_WAIT or mid-ERROR aborts the wait and returns the block to RUN.
- State registers: state {RUN, MEM_WAIT, ERROR}; wait_cnt holds $clog2(TIMEOUT_CYCLES)+1 bits.
- Control outputs are combinational from the current state and inputs, with zero latency. Only state and counters are registered.
- freeze = (state==RUN & dmem_req_i & ~dmem_ack_i) | (state==MEM_WAIT & ~dmem_ack_i) | (state==ERROR).
- load_use = IDEX_MemRead_i & (IDEX_RDaddr_i!=0) & (IDEX_RDaddr_i==IFID_RS1addr_i | IDEX_RDaddr_i==IFID_RS2addr_i).
- Output priority (highest first):
  - freeze: pipe_stall_o=1, PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0, IDEXBubble_o=0. Registers simply hold.
  - load_use: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1, IFIDFlush_o=0. A simultaneous Branch_i is ignored; the branch re-resolves next cycle.
  - Branch_i: PCWrite_o=1, IFIDWrite_o=1, IFIDFlush_o=1, IDEXBubble_o=0.
  - Otherwise: PCWrite_o=1, IFIDWrite_o=1, all others 0.
- Transitions:
  - RUN -> MEM_WAIT when dmem_req_i & ~dmem_ack_i; wait_cnt<=1. If req & ack arrive together, stay in RUN with no stall.
  - MEM_WAIT -> RUN on dmem_ack_i; wait_cnt<=0. The pipeline advances in the ack cycle (freeze=0).
  - MEM_WAIT: when ~dmem_ack_i, wait_cnt increments. When wait_cnt==TIMEOUT_CYCLES-1 and ~dmem_ack_i, go to ERROR.
  - ERROR: err_o=1 and freeze held until reset. dmem_ack_i is ignored.
- dmem_req_i deasserted in MEM_WAIT is a protocol violation; the block continues waiting for ack.
- stall_cnt_o increments by 1 on every cycle where freeze|load_use. It holds at 2^CNT_W-1 and does not wrap.
- rd=x0 never causes a load-use stall.

Test Plan:
- Load-use: IDEX_MemRead_i=1, RDaddr=5, RS1addr=5 -> that cycle PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1; stall_cnt_o 0->1; RDaddr=0 with RS1addr=0 -> no stall.
- Load-use and Branch_i together: RDaddr=7, RS2addr=7, Branch_i=1 -> IFIDFlush_o=0, IDEXBubble_o=1; next cycle Branch_i=1 with no hazard -> IFIDFlush_o=1, PCWrite_o=1.
- Memory wait: dmem_req_i=1 with ack low for 3 cycles, then ack -> pipe_stall_o=1 for exactly 3 cycles, 0 in the ack cycle; state back in RUN; stall_cnt_o=3.
- Zero-wait access: req=1 and ack=1 in the same cycle -> pipe_stall_o=0, state stays RUN, stall_cnt_o unchanged.
- Timeout: TIMEOUT_CYCLES=4, req=1, ack never -> err_o=1 from the 5th clock edge onward, pipe_stall_o stays 1; late ack has no effect; rst_i pulse -> err_o=0, stall_cnt_o=0, state RUN.
- Saturation and reset: CNT_W=4, 20 consecutive freeze cycles -> stall_cnt_o=15 and holds; rst_i asserted asynchronously mid-MEM_WAIT -> outputs immediately take their reset values.
